zorro2_fastram_responder: RTL

- Target-side 68000 bus responder: answers bus cycles decoded for this board. It is the counterpart of the accelerator's bus initiator.
- Provides one AutoConfig (Zorro II) memory board: config nibble reads, base-address and shut-up writes, and FastRAM chip selects.
- Generates DTACK_n for both FastRAM and AutoConfig accesses.
- Sits between the CPU-side strobes (AS_n, UDS_n/LDS_n, RW, ADDRESS, DATA[15:12]) and the RAM chip-select pins.

---
 rtl/zorro2_fastram_responder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/zorro2_fastram_responder.sv
// Zorro II AutoConfig FastRAM target: config nibble reads, base/shut-up writes, RAM selects, DTACK_n.
// Optional FASTRAM_ZERO_WAIT_EN: FastRAM cycles acknowledge on the decode edge itself.
module zorro2_fastram_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [2:0]  SIZE_CODE   = 3'b000,
  parameter logic [7:0]  PRODUCT_ID  = 8'h98,
  parameter logic [15:0] MANUF_ID    = 16'h07DB
) (
  input  logic        CPU_CLK,
  input  logic        RESET_n,
  input  logic        AS_n,
  input  logic        UDS_n,
  input  logic        LDS_n,
  input  logic        RW,
  input  logic [23:1] ADDRESS,
  input  logic [3:0]  DATA_IN,
  output logic        DTACK_n,
  output logic [1:0]  RAM_CS_n,
  output logic [3:0]  DATA_OUT,
  output logic        DATA_OE,
  output logic        CONFIGURED,
  output logic        SHUTUP,
  output logic [7:0]  BASE
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, END} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  wait_cnt_reg, wait_cnt_next;
  logic        is_ac_reg, is_ac_next;
  logic        dtack_n_reg, dtack_n_next;
  logic [1:0]  ram_cs_n_reg, ram_cs_n_next;
  logic [3:0]  data_out_reg, data_out_next;
  logic        data_oe_reg, data_oe_next;
  logic        configured_reg, configured_next;
  logic        shutup_reg, shutup_next;
  logic [7:0]  base_reg, base_next;
  logic        as_meta_reg, as_s_reg;

  logic        ac_addr, ram_match, ram_addr;
  logic [7:0]  ac_offset;
  logic [3:0]  ac_nibble;
  logic        unused_addr;

  assign unused_addr = ^ADDRESS[15:8];

  // AS_n is the only strobe crossing in asynchronously; the rest are stable while it is low.
  always_ff @(posedge CPU_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      as_meta_reg <= 1'b1;
      as_s_reg    <= 1'b1;
    end else begin
      as_meta_reg <= AS_n;
      as_s_reg    <= as_meta_reg;
    end
  end

  assign ac_offset = {ADDRESS[7:1], 1'b0};
  assign ac_addr   = (ADDRESS[23:16] == 8'hE8) && !configured_reg && !shutup_reg;

  always_comb begin
    case (SIZE_CODE)
      3'b110:  ram_match = (ADDRESS[23:21] == base_reg[7:5]);
      3'b111:  ram_match = (ADDRESS[23:22] == base_reg[7:6]);
      default: ram_match = (ADDRESS[23] == base_reg[7]);
    endcase
  end

  assign ram_addr = configured_reg && ram_match;

  always_comb begin
    case (ac_offset)
      8'h00:   ac_nibble = 4'hE;
      8'h02:   ac_nibble = {1'b0, SIZE_CODE};
      8'h04:   ac_nibble = ~PRODUCT_ID[7:4];
      8'h06:   ac_nibble = ~PRODUCT_ID[3:0];
      8'h08:   ac_nibble = 4'h7;
      8'h0A:   ac_nibble = 4'hF;
      8'h10:   ac_nibble = ~MANUF_ID[15:12];
      8'h12:   ac_nibble = ~MANUF_ID[11:8];
      8'h14:   ac_nibble = ~MANUF_ID[7:4];
      8'h16:   ac_nibble = ~MANUF_ID[3:0];
      default: ac_nibble = 4'hF;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    wait_cnt_next   = wait_cnt_reg;
    is_ac_next      = is_ac_reg;
    dtack_n_next    = dtack_n_reg;
    ram_cs_n_next   = ram_cs_n_reg;
    data_out_next   = data_out_reg;
    data_oe_next    = data_oe_reg;
    configured_next = configured_reg;
    shutup_next     = shutup_reg;
    base_next       = base_reg;

    case (state_reg)
      IDLE: begin
        if (!as_s_reg) begin
          if (ac_addr || ram_addr) begin
            state_next    = WAIT;
            wait_cnt_next = 2'(WAIT_STATES);
            is_ac_next    = ac_addr;
            if (ram_addr) begin
              ram_cs_n_next = {UDS_n, LDS_n};
`ifdef FASTRAM_ZERO_WAIT_EN
              state_next    = ACK;
              dtack_n_next  = 1'b0;
`endif
            end
            if (ac_addr && RW) begin
              data_oe_next  = 1'b1;
              data_out_next = ac_nibble;
            end
          end else begin
            state_next = END;
          end
        end
      end

      WAIT: begin
        // Strobe withdrawn before acknowledge: abandon without applying any write.
        if (as_s_reg) begin
          state_next    = END;
          dtack_n_next  = 1'b1;
          ram_cs_n_next = 2'b11;
          data_oe_next  = 1'b0;
          data_out_next = 4'hF;
        end else if (wait_cnt_reg == 2'd0) begin
          state_next   = ACK;
          dtack_n_next = 1'b0;
          if (is_ac_reg && !RW && !UDS_n) begin
            case (ac_offset)
              8'h4A: base_next[3:0] = DATA_IN;
              8'h48: begin
                base_next[7:4]  = DATA_IN;
                configured_next = 1'b1;
              end
              8'h4C: shutup_next = 1'b1;
              default: ;
            endcase
          end
        end else begin
          wait_cnt_next = wait_cnt_reg - 2'd1;
        end
      end

      ACK: begin
        if (as_s_reg) begin
          state_next    = END;
          dtack_n_next  = 1'b1;
          ram_cs_n_next = 2'b11;
          data_oe_next  = 1'b0;
          data_out_next = 4'hF;
        end
      end

      END: begin
        state_next    = IDLE;
        dtack_n_next  = 1'b1;
        ram_cs_n_next = 2'b11;
        data_oe_next  = 1'b0;
        data_out_next = 4'hF;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CPU_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= 2'd0;
      is_ac_reg      <= 1'b0;
      dtack_n_reg    <= 1'b1;
      ram_cs_n_reg   <= 2'b11;
      data_out_reg   <= 4'hF;
      data_oe_reg    <= 1'b0;
      configured_reg <= 1'b0;
      shutup_reg     <= 1'b0;
      base_reg       <= 8'h00;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      is_ac_reg      <= is_ac_next;
      dtack_n_reg    <= dtack_n_next;
      ram_cs_n_reg   <= ram_cs_n_next;
      data_out_reg   <= data_out_next;
      data_oe_reg    <= data_oe_next;
      configured_reg <= configured_next;
      shutup_reg     <= shutup_next;
      base_reg       <= base_next;
    end
  end

  assign DTACK_n    = dtack_n_reg;
  assign RAM_CS_n   = ram_cs_n_reg;
  assign DATA_OUT   = data_out_reg;
  assign DATA_OE    = data_oe_reg;
  assign CONFIGURED = configured_reg;
  assign SHUTUP     = shutup_reg;
  assign BASE       = base_reg;

endmodule
